isq: RTL and testbench

//  Instruction sequencer; sits directly upstream of the microcode decoder block.

---
 rtl/isq.sv | 107 ++++++++++
 tb/tb_isq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isq.sv
// Instruction sequencer: fetches opcode plus up to three operand bytes over a
// req/rdy handshake, then steps the microcode index until the decoder ends the insn.
module isq #(
  parameter int                ADDR_W   = 16,
  parameter int                STEPS    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_data,
  input  logic              mem_rdy,
  input  logic [1:0]        len,
  input  logic              pc_lrc,
  input  logic              pc_ini,
  input  logic [ADDR_W-1:0] pc_ld,
  output logic [7:0]        insn,
  output logic [7:0]        d1,
  output logic [7:0]        d2,
  output logic [7:0]        d3,
  output logic [2:0]        is,
  output logic              ex_en,
  output logic [ADDR_W-1:0] pc_out
);

  // state  | meaning
  // S_FOP  | fetch opcode byte at pc
  // S_LEN  | one-cycle wait while the decoder resolves len for the new opcode
  // S_FOPS | fetch operand bytes until len of them have arrived
  // S_EXEC | step microcode index until a decoder strobe or the last step
  typedef enum logic [1:0] {S_FOP, S_LEN, S_FOPS, S_EXEC} state_t;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FOP;
      pc    <= RESET_PC;
      insn  <= '0;
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
      is    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_FOP: begin
          if (mem_rdy) begin
            insn  <= mem_data;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            is    <= '0;
            pc    <= pc + 1'b1;
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (len == 2'd0) begin
            state <= S_EXEC;
          end else begin
            cnt   <= '0;
            state <= S_FOPS;
          end
        end
        S_FOPS: begin
          if (mem_rdy) begin
            case (cnt)
              2'd0:    d1 <= mem_data;
              2'd1:    d2 <= mem_data;
              2'd2:    d3 <= mem_data;
              default: ;
            endcase
            pc  <= pc + 1'b1;
            cnt <= cnt + 1'b1;
            if (cnt == len - 2'd1) state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // a jump wins over a plain end when both strobes arrive together
          if (pc_lrc) begin
            pc    <= pc_ld;
            is    <= '0;
            state <= S_FOP;
          end else if (pc_ini || is == LAST_STEP) begin
            is    <= '0;
            state <= S_FOP;
          end else begin
            is <= is + 3'd1;
          end
        end
        default: state <= S_FOP;
      endcase
    end
  end

  assign mem_re   = !rst && (state == S_FOP || state == S_FOPS);
  assign ex_en    = !rst && (state == S_EXEC);
  assign mem_addr = pc;
  assign pc_out   = pc;

endmodule

// File: tb/tb_isq.sv
// Randomized scoreboard bench for isq: instruction-level reference model feeds
// expected results to a monitor that checks each execution window.
module tb_isq;

  localparam logic [15:0] RPC = 16'hFFFF;
  localparam int N_INSN = 40;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_data = 0;
  logic        mem_rdy = 0;
  logic [1:0]  len;
  logic        pc_lrc = 0;
  logic        pc_ini = 0;
  logic [15:0] pc_ld = 0;
  logic [7:0]  insn, d1, d2, d3;
  logic [2:0]  is;
  logic        ex_en;
  logic [15:0] pc_out;

  isq #(.ADDR_W(16), .STEPS(8), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_data(mem_data), .mem_rdy(mem_rdy), .len(len), .pc_lrc(pc_lrc),
    .pc_ini(pc_ini), .pc_ld(pc_ld), .insn(insn), .d1(d1), .d2(d2), .d3(d3),
    .is(is), .ex_en(ex_en), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // stand-in decoder: operand count is the opcode's two low bits
  assign len = insn[1:0];

  typedef struct {
    logic [7:0]  insn, d1, d2, d3;
    logic [15:0] pc_exec, pc_next;
    int          steps;
  } exp_t;
  typedef struct {
    int          kind;   // 0 implicit end, 1 pc_ini, 2 pc_lrc, 3 both
    int          k;
    logic [15:0] tgt;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;
  bit auto_mem = 0;
  bit mon_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // memory responder with random wait states
  int          wait_left = 0;
  bit          armed = 0;
  logic [15:0] held;
  always @(negedge clk) begin
    if (auto_mem) begin
      mem_rdy  = 0;
      mem_data = 8'($urandom);
      if (mem_re === 1'b1) begin
        if (armed) check("hold_addr", {16'h0, mem_addr}, {16'h0, held});
        else begin
          armed = 1;
          held = mem_addr;
          wait_left = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        end
        if (wait_left == 0) begin
          mem_rdy  = 1;
          mem_data = mem[mem_addr];
          armed    = 0;
        end else wait_left--;
      end else armed = 0;
    end
  end

  // strobe driver: ends each execution as planned, random noise outside exec
  bit    drv_in = 0;
  int    drv_cyc = 0;
  plan_t cur;
  always @(negedge clk) begin
    if (ex_en === 1'b1) begin
      if (!drv_in) begin
        drv_in = 1;
        drv_cyc = 0;
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else cur = '{kind: 0, k: 99, tgt: 16'h0};
      end
      pc_ini = (drv_cyc == cur.k) && (cur.kind == 1 || cur.kind == 3);
      pc_lrc = (drv_cyc == cur.k) && (cur.kind >= 2);
      pc_ld  = pc_lrc ? cur.tgt : 16'($urandom);
      drv_cyc++;
    end else begin
      drv_in = 0;
      pc_ini = ($urandom_range(0, 3) == 0);
      pc_lrc = ($urandom_range(0, 3) == 0);
      pc_ld  = 16'($urandom);
    end
  end

  // monitor: checks each execution window against the scoreboard
  bit   mon_in = 0;
  int   mon_cyc = 0;
  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (ex_en === 1'b1) begin
        if (!mon_in) begin
          mon_in = 1;
          mon_cyc = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL exp_underflow: got unexpected exec expected none at %0t", $time);
            e = '{insn: 0, d1: 0, d2: 0, d3: 0, pc_exec: 0, pc_next: 0, steps: 0};
          end else begin
            e = exp_q.pop_front();
            check("insn", {24'h0, insn}, {24'h0, e.insn});
            check("operands", {8'h0, d1, d2, d3}, {8'h0, e.d1, e.d2, e.d3});
            check("pc_exec", {16'h0, pc_out}, {16'h0, e.pc_exec});
          end
        end
        check("is_step", {29'h0, is}, 32'(mon_cyc));
        mon_cyc++;
      end else begin
        if (mon_in) begin
          mon_in = 0;
          check("exec_len", 32'(mon_cyc), 32'(e.steps));
          check("pc_next", {16'h0, pc_out}, {16'h0, e.pc_next});
          check("fetch_addr", {16'h0, mem_addr}, {16'h0, e.pc_next});
          check("fetch_re", {31'h0, mem_re}, 32'd1);
        end
        check("is_idle", {29'h0, is}, 32'd0);
      end
    end
  end

  initial begin
    logic [15:0] pcm, a;
    logic [1:0]  l;
    exp_t        x;
    plan_t       p;
    bit          done;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFF] = {6'($urandom), 2'b11};

    // reference model: walk the program one instruction at a time
    pcm = RPC;
    for (int i = 0; i < N_INSN; i++) begin
      x.insn = mem[pcm];
      l = x.insn[1:0];
      x.d1 = 0; x.d2 = 0; x.d3 = 0;
      a = pcm + 16'd1;
      if (l >= 1) begin x.d1 = mem[a]; a = a + 16'd1; end
      if (l >= 2) begin x.d2 = mem[a]; a = a + 16'd1; end
      if (l >= 3) begin x.d3 = mem[a]; a = a + 16'd1; end
      x.pc_exec = a;
      p.kind = $urandom_range(0, 3);
      p.k    = $urandom_range(0, 7);
      p.tgt  = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2))
                                           : 16'($urandom);
      x.steps   = (p.kind == 0) ? 8 : p.k + 1;
      x.pc_next = (p.kind >= 2) ? p.tgt : x.pc_exec;
      plan_q.push_back(p);
      exp_q.push_back(x);
      pcm = x.pc_next;
    end

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", {16'h0, pc_out}, {16'h0, RPC});
    check("rst_is", {29'h0, is}, 32'd0);
    check("rst_mem_re", {31'h0, mem_re}, 32'd0);
    check("rst_ex_en", {31'h0, ex_en}, 32'd0);
    check("rst_insn", {24'h0, insn}, 32'd0);
    rst = 0;
    #1;
    check("post_rst_re", {31'h0, mem_re}, 32'd1);
    check("post_rst_addr", {16'h0, mem_addr}, {16'h0, RPC});
    auto_mem = 1;
    mon_en = 1;

    done = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !mon_in) begin
        auto_mem = 0;
        mem_rdy = 0;
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL run_timeout: got %0d pending expected 0", exp_q.size());
    end else begin
      // reset pulse in the middle of an operand fetch across the address wrap
      @(negedge clk); rst = 1;
      @(negedge clk);
      @(negedge clk); rst = 0;
      mem_rdy = 1; mem_data = mem[16'hFFFF];
      @(negedge clk); mem_rdy = 0;
      @(negedge clk);
      check("wrap_opnd_addr", {16'h0, mem_addr}, 32'd0);
      check("wrap_opnd_re", {31'h0, mem_re}, 32'd1);
      mem_rdy = 1; mem_data = mem[0];
      @(negedge clk); mem_rdy = 0;
      check("wrap_d1", {24'h0, d1}, {24'h0, mem[0]});
      check("wrap_pc", {16'h0, pc_out}, 32'd1);
      rst = 1;
      @(negedge clk);
      check("midrst_addr", {16'h0, mem_addr}, {16'h0, RPC});
      check("midrst_insn", {24'h0, insn}, 32'd0);
      check("midrst_d1", {24'h0, d1}, 32'd0);
      check("midrst_ex_en", {31'h0, ex_en}, 32'd0);
      check("midrst_re", {31'h0, mem_re}, 32'd0);
      rst = 0;
      #1;
      check("midrst_refetch", {31'h0, mem_re}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
